master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/bus_pkg.sv | 24 ++
 rtl/master_port_counter.sv | 36 +++
 rtl/master_port.sv | 205 ++++++++++++++++++++
 tb/tb_master_port.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial bus master: transaction FSM state enum,
// address/data widths, default acknowledge timeout and counter width.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned ACK_TIMEOUT_DEF = 15;
    // Wide enough for the largest legal timeout (255) and for ADDR_W bit steps.
    localparam int unsigned CNT_W           = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        WDATA,
        ACK_D,
        RDATA,
        DONE
    } state_t;

endpackage

// File: rtl/master_port_counter.sv
// -----------------------------------------------------------------------------
// master_port_counter
// Shared up-counter used for serial bit indexing and ack-timeout counting.
// Synchronous clear has priority over increment; the count saturates at its
// maximum so an indefinite wait can never wrap back into a valid index.
//
// Ports:
//   CLK    in   rising-edge clock
//   RSTN   in   asynchronous active-low reset
//   rst    in   synchronous clear
//   incr   in   increment enable
//   count  out  current count
// -----------------------------------------------------------------------------
module master_port_counter
    import bus_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         rst,
    input  logic         incr,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count <= '0;
        end else if (rst) begin
            count <= '0;
        end else if (incr && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/master_port.sv
// -----------------------------------------------------------------------------
// master_port
// Serial bus master. Accepts a request on M_START while idle, shifts the
// 16-bit address out LSB first, waits for a slave acknowledge, then either
// shifts 8 bits of write data out (and waits for a second acknowledge) or
// reads 8 bits back after one turnaround cycle. M_DONE pulses for one cycle
// at completion; M_RDATA is updated on successful reads and held otherwise.
//
// Optional feature (macro MASTER_ACK_TIMEOUT_EN): the acknowledge states give
// up after ACK_TIMEOUT cycles without B_ACK and complete with M_ERR=1.
// Without the macro the acknowledge states wait indefinitely and M_ERR=0.
//
// Parameters:
//   ACK_TIMEOUT  cycles to wait for B_ACK (2..255)
// Ports:
//   CLK, RSTN    clock / asynchronous active-low reset
//   M_START      request strobe (accepted only while M_READY=1)
//   M_RW         1=write, 0=read
//   M_ADDR       target address
//   M_WDATA      write data
//   M_READY      idle, can accept a request
//   M_DONE       one-cycle completion pulse
//   M_ERR        qualifies M_DONE: acknowledge timeout
//   M_RDATA      read data, held until the next successful read
//   B_AD_VALID   high during the 16 address-bit cycles
//   B_BUS_OUT    serial address / write data, LSB first
//   B_RW         registered M_RW for the transaction
//   B_BUS_IN     serial read data from slave
//   B_ACK        slave acknowledge
//   B_SBSY       slave busy (informational, not used for control)
// -----------------------------------------------------------------------------
module master_port
    import bus_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              M_START,
    input  logic              M_RW,
    input  logic [ADDR_W-1:0] M_ADDR,
    input  logic [DATA_W-1:0] M_WDATA,
    output logic              M_READY,
    output logic              M_DONE,
    output logic              M_ERR,
    output logic [DATA_W-1:0] M_RDATA,
    output logic              B_AD_VALID,
    output logic              B_BUS_OUT,
    output logic              B_RW,
    input  logic              B_BUS_IN,
    input  logic              B_ACK,
    input  logic              B_SBSY
);

    if ((ACK_TIMEOUT < 2) || (ACK_TIMEOUT > 255)) begin : g_bad_timeout
        $error("master_port: ACK_TIMEOUT must be in 2..255");
    end

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic               cnt_rst;
    logic               cnt_incr;
    logic               timeout;
    logic               in_ack;

    logic               rw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_sh;
    logic [DATA_W-1:0]  rdata_next;
    logic [DATA_W-1:0]  rdata_q;
    logic [2:0]         rd_idx;
    logic               unused_sbsy;

    assign unused_sbsy = B_SBSY;
    assign in_ack      = (state == ACK_A) || (state == ACK_D);

    master_port_counter #(
        .W (CNT_W)
    ) u_counter (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .rst   (cnt_rst),
        .incr  (cnt_incr),
        .count (count)
    );

`ifdef MASTER_ACK_TIMEOUT_EN
    logic err_q;

    // Count 0 is the entry cycle, so the last waiting cycle is ACK_TIMEOUT-1.
    assign timeout = in_ack && !B_ACK && (count == CNT_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && M_START) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign M_ERR = (state == DONE) && err_q;
`else
    assign timeout = 1'b0;
    assign M_ERR   = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (M_START) next_state = ADDR;
            end
            ADDR: begin
                if (count == CNT_W'(ADDR_W - 1)) next_state = ACK_A;
            end
            ACK_A: begin
                if (B_ACK)        next_state = rw_q ? WDATA : RDATA;
                else if (timeout) next_state = DONE;
            end
            WDATA: begin
                if (count == CNT_W'(DATA_W - 1)) next_state = ACK_D;
            end
            ACK_D: begin
                if (B_ACK || timeout) next_state = DONE;
            end
            RDATA: begin
                // Count 0 is turnaround; counts 1..DATA_W carry data bits.
                if (count == CNT_W'(DATA_W)) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output / control logic
    always_comb begin
        M_READY    = (state == IDLE);
        M_DONE     = (state == DONE);
        B_AD_VALID = (state == ADDR);
        B_BUS_OUT  = 1'b0;
        if (state == ADDR) begin
            B_BUS_OUT = addr_q[count[3:0]];
        end else if (state == WDATA) begin
            B_BUS_OUT = wdata_q[count[2:0]];
        end
        // Clearing on every transition gives each state a fresh bit index.
        cnt_rst  = (next_state != state);
        cnt_incr = (state == ADDR) || (state == WDATA) || (state == RDATA);
`ifdef MASTER_ACK_TIMEOUT_EN
        cnt_incr = cnt_incr || in_ack;
`endif
    end

    // Read bit k arrives at count k+1; the final bit is merged combinationally
    // so M_RDATA is already valid in the DONE cycle.
    always_comb begin
        rd_idx             = count[2:0] - 3'd1;
        rdata_next         = rdata_sh;
        rdata_next[rd_idx] = B_BUS_IN;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_sh <= '0;
            rdata_q  <= '0;
        end else begin
            if ((state == IDLE) && M_START) begin
                rw_q    <= M_RW;
                addr_q  <= M_ADDR;
                wdata_q <= M_WDATA;
            end
            if ((state == RDATA) && (count != '0)) begin
                rdata_sh <= rdata_next;
                if (count == CNT_W'(DATA_W)) begin
                    rdata_q <= rdata_next;
                end
            end
        end
    end

    assign B_RW    = rw_q;
    assign M_RDATA = rdata_q;

endmodule

// File: tb/tb_master_port.sv
module tb_master_port;

    localparam int ACK_TO = 15;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        M_START = 1'b0;
    logic        M_RW = 1'b0;
    logic [15:0] M_ADDR = '0;
    logic [7:0]  M_WDATA = '0;
    logic        M_READY, M_DONE, M_ERR;
    logic [7:0]  M_RDATA;
    logic        B_AD_VALID, B_BUS_OUT, B_RW;
    logic        B_BUS_IN = 1'b0;
    logic        B_ACK = 1'b0;
    logic        B_SBSY = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } res_t;

    logic       exp_bits[$];
    res_t       exp_res[$];
    logic [7:0] model_rdata = 8'h00;

    master_port #(
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .M_START    (M_START),
        .M_RW       (M_RW),
        .M_ADDR     (M_ADDR),
        .M_WDATA    (M_WDATA),
        .M_READY    (M_READY),
        .M_DONE     (M_DONE),
        .M_ERR      (M_ERR),
        .M_RDATA    (M_RDATA),
        .B_AD_VALID (B_AD_VALID),
        .B_BUS_OUT  (B_BUS_OUT),
        .B_RW       (B_RW),
        .B_BUS_IN   (B_BUS_IN),
        .B_ACK      (B_ACK),
        .B_SBSY     (B_SBSY)
    );

    always #5 CLK = ~CLK;

    // Full transaction: drives the request, plays the slave, checks every cycle.
    // a_dly/d_dly: cycles after ack-state entry before B_ACK (-1 = never).
    task automatic run_txn(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] slave_rd, input int a_dly, input int d_dly,
                           input int glitch_at);
        res_t r;
        logic eb;
        logic timed;
        timed = (a_dly < 0);
        @(negedge CLK);
        checks++;
        if (M_READY !== 1'b1) begin
            failures++;
            $display("FAIL ready_at_start: got %b want 1", M_READY);
        end
        M_START = 1'b1; M_RW = rw; M_ADDR = addr; M_WDATA = wd;
        for (int i = 0; i < 16; i++) exp_bits.push_back(addr[i]);
        if (rw && !timed) for (int i = 0; i < 8; i++) exp_bits.push_back(wd[i]);
        if (!timed && !rw) model_rdata = slave_rd;
        r.rdata = model_rdata;
        r.err   = timed;
        exp_res.push_back(r);

        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            M_START = (i == glitch_at);
            if (i == glitch_at) begin
                M_RW = ~rw; M_ADDR = ~addr; M_WDATA = ~wd;
            end
            checks++;
            if (exp_bits.size() == 0) begin
                failures++;
                $display("FAIL addr_bit%0d: scoreboard empty", i);
            end else begin
                eb = exp_bits.pop_front();
                if ({B_AD_VALID, B_BUS_OUT, B_RW, M_READY, M_DONE} !== {1'b1, eb, rw, 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL addr_bit%0d: valid/out/rw/ready/done got %b%b%b%b%b want 1%b%b00",
                             i, B_AD_VALID, B_BUS_OUT, B_RW, M_READY, M_DONE, eb, rw);
                end
            end
        end
        M_START = 1'b0;

        if (timed) begin
            for (int d = 0; d < ACK_TO; d++) begin
                @(negedge CLK);
                B_ACK = 1'b0;
                checks++;
                if ({B_AD_VALID, B_BUS_OUT, M_DONE} !== 3'b000) begin
                    failures++;
                    $display("FAIL ack_wait%0d: valid/out/done got %b%b%b want 000",
                             d, B_AD_VALID, B_BUS_OUT, M_DONE);
                end
            end
        end else begin
            for (int d = 0; d <= a_dly; d++) begin
                @(negedge CLK);
                B_ACK = (d == a_dly);
                checks++;
                if ({B_AD_VALID, B_BUS_OUT, M_DONE} !== 3'b000) begin
                    failures++;
                    $display("FAIL ack_a%0d: valid/out/done got %b%b%b want 000",
                             d, B_AD_VALID, B_BUS_OUT, M_DONE);
                end
            end
            if (rw) begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge CLK);
                    B_ACK = 1'b0;
                    checks++;
                    if (exp_bits.size() == 0) begin
                        failures++;
                        $display("FAIL wdata_bit%0d: scoreboard empty", k);
                    end else begin
                        eb = exp_bits.pop_front();
                        if ({B_AD_VALID, B_BUS_OUT, M_DONE} !== {1'b0, eb, 1'b0}) begin
                            failures++;
                            $display("FAIL wdata_bit%0d: valid/out/done got %b%b%b want 0%b0",
                                     k, B_AD_VALID, B_BUS_OUT, M_DONE, eb);
                        end
                    end
                end
                for (int d = 0; d <= d_dly; d++) begin
                    @(negedge CLK);
                    B_ACK = (d == d_dly);
                    checks++;
                    if ({B_BUS_OUT, M_DONE} !== 2'b00) begin
                        failures++;
                        $display("FAIL ack_d%0d: out/done got %b%b want 00", d, B_BUS_OUT, M_DONE);
                    end
                end
            end else begin
                // Turnaround: drive the opposite of bit 0 to expose early sampling.
                @(negedge CLK);
                B_ACK = 1'b0;
                B_BUS_IN = ~slave_rd[0];
                for (int k = 0; k < 8; k++) begin
                    @(negedge CLK);
                    B_BUS_IN = slave_rd[k];
                    checks++;
                    if ({B_BUS_OUT, B_RW, M_DONE} !== 3'b000) begin
                        failures++;
                        $display("FAIL rdata_bit%0d: out/rw/done got %b%b%b want 000",
                                 k, B_BUS_OUT, B_RW, M_DONE);
                    end
                end
            end
        end

        @(negedge CLK);
        B_ACK = 1'b0;
        B_BUS_IN = 1'b0;
        checks++;
        if (exp_res.size() == 0) begin
            failures++;
            $display("FAIL done: result scoreboard empty");
        end else begin
            r = exp_res.pop_front();
            if ({M_DONE, M_ERR, M_RDATA} !== {1'b1, r.err, r.rdata}) begin
                failures++;
                $display("FAIL done: done/err/rdata got %b/%b/%h want 1/%b/%h",
                         M_DONE, M_ERR, M_RDATA, r.err, r.rdata);
            end
        end
        checks++;
        if (exp_bits.size() != 0) begin
            failures++;
            $display("FAIL leftover_bits: got %0d want 0", exp_bits.size());
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            checks++;
            if ({M_READY, M_DONE, B_AD_VALID, B_BUS_OUT} !== 4'b1000) begin
                failures++;
                $display("FAIL %s%0d: ready/done/valid/out got %b%b%b%b want 1000",
                         name, c, M_READY, M_DONE, B_AD_VALID, B_BUS_OUT);
            end
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        #2;
        checks++;
        if ({M_READY, M_DONE, M_ERR, M_RDATA, B_AD_VALID, B_BUS_OUT, B_RW} !== {3'b100, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_state: got %b%b%b %h %b%b%b want 100 00 000",
                     M_READY, M_DONE, M_ERR, M_RDATA, B_AD_VALID, B_BUS_OUT, B_RW);
        end
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        check_idle("reset_idle", 2);
    endtask

    task automatic test_write();
        run_txn(1'b1, 16'h1234, 8'hA5, 8'h00, 2, 2, -1);
        check_idle("write_after", 3);
    endtask

    task automatic test_read();
        run_txn(1'b0, 16'h0008, 8'h00, 8'h3C, 2, 0, -1);
        check_idle("read_after", 2);
    endtask

    task automatic test_ignore_start();
        run_txn(1'b1, 16'h0F0F, 8'h33, 8'h00, 1, 0, 5);
        check_idle("ignore_after", 4);
    endtask

    // Immediate acks and no idle gap: each run_txn begins on the first ready cycle.
    task automatic test_back_to_back();
        run_txn(1'b1, 16'hBEEF, 8'h5A, 8'h00, 0, 0, -1);
        run_txn(1'b0, 16'hFFFF, 8'h00, 8'hC3, 0, 0, -1);
        run_txn(1'b0, 16'h8001, 8'h00, 8'h81, 0, 0, -1);
        run_txn(1'b1, 16'h0000, 8'hFF, 8'h00, 0, 0, -1);
        check_idle("b2b_after", 2);
    endtask

`ifdef MASTER_ACK_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b1, 16'hABCD, 8'h11, 8'h00, -1, 0, -1);
        run_txn(1'b0, 16'h1357, 8'h00, 8'hEE, -1, 0, -1);
        check_idle("timeout_after", 2);
        run_txn(1'b0, 16'h2468, 8'h00, 8'h96, 1, 0, -1);
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge CLK);
        M_START = 1'b1; M_RW = 1'b1; M_ADDR = 16'hFFFF; M_WDATA = 8'hFF;
        for (int i = 0; i <= 7; i++) begin
            @(negedge CLK);
            M_START = 1'b0;
        end
        RSTN = 1'b0;
        #1;
        checks++;
        if ({M_READY, M_DONE, M_ERR, M_RDATA, B_AD_VALID, B_BUS_OUT, B_RW} !== {3'b100, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_mid: got %b%b%b %h %b%b%b want 100 00 000",
                     M_READY, M_DONE, M_ERR, M_RDATA, B_AD_VALID, B_BUS_OUT, B_RW);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if ({M_DONE, B_AD_VALID} !== 2'b00) begin
                failures++;
                $display("FAIL reset_hold%0d: done/valid got %b%b want 00", c, M_DONE, B_AD_VALID);
            end
        end
        RSTN = 1'b1;
        exp_bits.delete();
        exp_res.delete();
        model_rdata = 8'h00;
        check_idle("reset_mid_idle", 2);
        run_txn(1'b0, 16'h00F0, 8'h00, 8'h69, 1, 0, -1);
        run_txn(1'b1, 16'h4321, 8'h0F, 8'h00, 0, 3, -1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore_start();
        test_back_to_back();
`ifdef MASTER_ACK_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
